// File: rtl/ex_stage.sv
// Execute stage: forwarded operand select, ALU, branch resolve, EX/MEM register and squash FSM.
// Optional FWD_EN enables MEM/WB forwarding; otherwise the hazard output flags RAW conflicts.
module ex_stage #(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC_DUMMY = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [3:0]      in_alu_op,
  input  logic [1:0]      in_src_a,
  input  logic            in_src_b,
  input  logic [2:0]      in_func3,
  input  logic            in_regwrite,
  input  logic            in_memread,
  input  logic            in_memwrite,
  input  logic            in_branch,
  input  logic            in_jal,
  input  logic            in_jalr,
  input  logic            in_compressed,
  input  logic            fwd_mem_we,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_we,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_func3,
  output logic            out_regwrite,
  output logic            out_memread,
  output logic            out_memwrite,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            hazard
);

  typedef enum logic [1:0] {StNormal, StSq2, StSq1} state_e;

  state_e          state_q, state_d;
  logic            eff_valid, taken, cond;
  logic [XLEN-1:0] rs1_val, rs2_val, op_a, op_b, alu_res, result, target, jalr_sum, link_off;
  logic [4:0]      shamt;

  logic            out_valid_q, out_regwrite_q, out_memread_q, out_memwrite_q;
  logic [XLEN-1:0] out_alu_result_q, out_store_data_q;
  logic [4:0]      out_rd_q;
  logic [2:0]      out_func3_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  assign eff_valid = in_valid && (state_q == StNormal);

`ifdef FWD_EN
  always_comb begin
    rs1_val = in_rs1_data;
    if (in_rs1 != 5'd0 && fwd_mem_we && fwd_mem_rd == in_rs1) rs1_val = fwd_mem_data;
    else if (in_rs1 != 5'd0 && fwd_wb_we && fwd_wb_rd == in_rs1) rs1_val = fwd_wb_data;
    rs2_val = in_rs2_data;
    if (in_rs2 != 5'd0 && fwd_mem_we && fwd_mem_rd == in_rs2) rs2_val = fwd_mem_data;
    else if (in_rs2 != 5'd0 && fwd_wb_we && fwd_wb_rd == in_rs2) rs2_val = fwd_wb_data;
  end
  assign hazard = 1'b0;
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^{fwd_mem_data, fwd_wb_data};
  assign rs1_val = in_rs1_data;
  assign rs2_val = in_rs2_data;
  assign hazard  = eff_valid &&
      ((in_rs1 != 5'd0 && ((fwd_mem_we && fwd_mem_rd == in_rs1) ||
                           (fwd_wb_we && fwd_wb_rd == in_rs1))) ||
       (in_rs2 != 5'd0 && ((fwd_mem_we && fwd_mem_rd == in_rs2) ||
                           (fwd_wb_we && fwd_wb_rd == in_rs2))));
`endif

  always_comb begin
    op_a = '0;
    if (in_src_a == 2'd0) op_a = rs1_val;
    else if (in_src_a == 2'd1) op_a = in_pc;
    op_b  = in_src_b ? in_imm : rs2_val;
    shamt = op_b[4:0];
    case (in_alu_op)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (in_func3)
      3'd0:    cond = rs1_val == rs2_val;
      3'd1:    cond = rs1_val != rs2_val;
      3'd4:    cond = $signed(rs1_val) < $signed(rs2_val);
      3'd5:    cond = $signed(rs1_val) >= $signed(rs2_val);
      3'd6:    cond = rs1_val < rs2_val;
      3'd7:    cond = rs1_val >= rs2_val;
      default: cond = 1'b0;
    endcase
  end

  assign taken    = eff_valid && (in_jal || in_jalr || (in_branch && cond));
  assign jalr_sum = rs1_val + in_imm;
  assign target   = in_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : in_pc + in_imm;
  assign link_off = in_compressed ? XLEN'(2) : XLEN'(4);
  assign result   = (in_jal || in_jalr) ? in_pc + link_off : alu_res;

  // Squash counts the next two consumed inputs after a taken transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StNormal: if (taken) state_d = StSq2;
      StSq2:    state_d = StSq1;
      StSq1:    state_d = StNormal;
      default:  state_d = StNormal;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StNormal;
      out_valid_q      <= 1'b0;
      out_alu_result_q <= '0;
      out_store_data_q <= '0;
      out_rd_q         <= '0;
      out_func3_q      <= '0;
      out_regwrite_q   <= 1'b0;
      out_memread_q    <= 1'b0;
      out_memwrite_q   <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= RESET_PC_DUMMY;
    end else begin
      // Redirect is a single-cycle pulse even if the next edge is stalled.
      redirect_valid_q <= !stall && taken;
      if (!stall) begin
        state_q          <= state_d;
        out_valid_q      <= eff_valid;
        out_alu_result_q <= result;
        out_store_data_q <= rs2_val;
        out_rd_q         <= in_rd;
        out_func3_q      <= in_func3;
        out_regwrite_q   <= in_regwrite && eff_valid;
        out_memread_q    <= in_memread && eff_valid;
        out_memwrite_q   <= in_memwrite && eff_valid;
        if (taken) redirect_pc_q <= target;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_alu_result = out_alu_result_q;
  assign out_store_data = out_store_data_q;
  assign out_rd         = out_rd_q;
  assign out_func3      = out_func3_q;
  assign out_regwrite   = out_regwrite_q;
  assign out_memread    = out_memread_q;
  assign out_memwrite   = out_memwrite_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_valid_q ? redirect_pc_q : RESET_PC_DUMMY;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected EX/MEM entries, a monitor pops them.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        in_valid, in_src_b, in_regwrite, in_memread, in_memwrite;
  logic        in_branch, in_jal, in_jalr, in_compressed;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [3:0]  in_alu_op;
  logic [1:0]  in_src_a;
  logic [2:0]  in_func3;
  logic        fwd_mem_we, fwd_wb_we;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid, out_regwrite, out_memread, out_memwrite, redirect_valid, hazard;
  logic [31:0] out_alu_result, out_store_data, redirect_pc;
  logic [4:0]  out_rd;
  logic [2:0]  out_func3;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic        memwrite;
    logic        chk;
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];

  ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_op(in_alu_op),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_func3(in_func3),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_branch(in_branch), .in_jal(in_jal), .in_jalr(in_jalr), .in_compressed(in_compressed),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_func3(out_func3), .out_regwrite(out_regwrite),
    .out_memread(out_memread), .out_memwrite(out_memwrite),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t ev(input logic v, input logic rw, input logic mw, input logic chk,
                              input logic [31:0] res, input logic [4:0] rd);
    exp_t e;
    e.valid = v; e.regwrite = rw; e.memwrite = mw; e.chk = chk; e.res = res; e.rd = rd;
    return e;
  endfunction

  // Monitor: every non-stalled, non-reset edge presents one EX/MEM entry.
  always @(posedge clk) begin
    logic st, rs;
    exp_t e;
    st = stall;
    rs = reset;
    #1;
    if (!rs && !st) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got empty queue expected an entry");
      end else begin
        e = exp_q.pop_front();
        check("out_valid", out_valid, e.valid);
        check("out_regwrite", out_regwrite, e.regwrite);
        check("out_memwrite", out_memwrite, e.memwrite);
        if (e.chk) begin
          check("out_alu_result", out_alu_result, e.res);
          check("out_rd", out_rd, e.rd);
        end
      end
    end
  end

  task automatic clear_inputs();
    in_valid = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_alu_op = 0; in_src_a = 0; in_src_b = 0;
    in_func3 = 0; in_regwrite = 0; in_memread = 0; in_memwrite = 0;
    in_branch = 0; in_jal = 0; in_jalr = 0; in_compressed = 0;
    fwd_mem_we = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
    fwd_wb_we = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
  endtask

  task automatic step(input exp_t e);
    if (!stall && !reset) exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alu_case(input logic [3:0] op, input logic [1:0] sa, input logic sb,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                          input logic [31:0] expv);
    clear_inputs();
    in_valid = 1; in_alu_op = op; in_src_a = sa; in_src_b = sb;
    in_rs1_data = a; in_rs2_data = b; in_imm = b; in_pc = pc;
    in_rd = 5'(op) + 5'd1; in_regwrite = 1;
    step(ev(1, 1, 0, 1, expv, 5'(op) + 5'd1));
  endtask

  task automatic drive_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    in_valid = 1; in_branch = 1; in_func3 = f3; in_pc = 32'h100; in_imm = 32'h20;
    in_rs1_data = a; in_rs2_data = b;
  endtask

  // Valid ALU op, and a jal to prove a wrong-path transfer cannot redirect.
  task automatic drive_wrong_path();
    clear_inputs();
    in_valid = 1; in_regwrite = 1; in_memwrite = 1; in_jal = 1; in_rd = 5'd7;
    in_pc = 32'h900; in_imm = 32'h40;
  endtask

  task automatic squash2();
    for (int i = 0; i < 2; i++) begin
      drive_wrong_path();
      step(ev(0, 0, 0, 0, 0, 0));
      check("squash_no_redirect", redirect_valid, 0);
    end
  endtask

  task automatic branch_case(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic exp_taken);
    drive_branch(f3, a, b);
    step(ev(1, 0, 0, 0, 0, 0));
    check("br_redirect_valid", redirect_valid, exp_taken);
    if (exp_taken) begin
      check("br_redirect_pc", redirect_pc, 32'h120);
      squash2();
    end
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_result", out_alu_result, 0);
    check("rst_regwrite", out_regwrite, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    reset = 0;

    // ALU operations and operand sources.
    alu_case(4'd0, 2'd0, 1'b0, 32'd5, 32'd7, 0, 32'd12);
    alu_case(4'd1, 2'd0, 1'b0, 32'd5, 32'd7, 0, 32'hFFFF_FFFE);
    alu_case(4'd2, 2'd0, 1'b0, 32'd1, 32'd33, 0, 32'd2);
    alu_case(4'd3, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 32'd1);
    alu_case(4'd4, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 32'd0);
    alu_case(4'd5, 2'd0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 0, 32'h0000_0FF0);
    alu_case(4'd6, 2'd0, 1'b0, 32'h8000_0000, 32'd4, 0, 32'h0800_0000);
    alu_case(4'd7, 2'd0, 1'b1, 32'h8000_0000, 32'd4, 0, 32'hF800_0000);
    alu_case(4'd8, 2'd0, 1'b0, 32'hF0, 32'h0F, 0, 32'hFF);
    alu_case(4'd9, 2'd0, 1'b0, 32'hF0, 32'h3C, 0, 32'h30);
    alu_case(4'd10, 2'd0, 1'b0, 32'h1234, 32'h55, 0, 32'h55);
    alu_case(4'd13, 2'd0, 1'b0, 32'd5, 32'd7, 0, 32'd0);
    alu_case(4'd0, 2'd1, 1'b1, 32'd99, 32'd8, 32'h1000, 32'h1008);
    alu_case(4'd0, 2'd2, 1'b1, 32'd99, 32'd8, 32'h1000, 32'd8);

    // Forwarding priority and rd==0 exclusion.
    clear_inputs();
    in_valid = 1; in_rs1 = 5'd4; in_rs1_data = 1; in_imm = 1; in_src_b = 1; in_rd = 5'd2;
    in_regwrite = 1;
    fwd_mem_we = 1; fwd_mem_rd = 5'd4; fwd_mem_data = 32'h10;
    fwd_wb_we = 1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'h20;
    #1;
`ifdef FWD_EN
    check("fwd_hazard", hazard, 0);
    step(ev(1, 1, 0, 1, 32'h11, 5'd2));
`else
    check("fwd_hazard", hazard, 1);
    step(ev(1, 1, 0, 1, 32'h2, 5'd2));
`endif
    fwd_mem_we = 0;
    #1;
`ifdef FWD_EN
    step(ev(1, 1, 0, 1, 32'h21, 5'd2));
`else
    check("wb_hazard", hazard, 1);
    step(ev(1, 1, 0, 1, 32'h2, 5'd2));
`endif
    fwd_mem_we = 1; fwd_mem_rd = 5'd0; in_rs1 = 5'd0; in_rs1_data = 0;
    #1;
    check("x0_hazard", hazard, 0);
    step(ev(1, 1, 0, 1, 32'h1, 5'd2));

    // Branch conditions.
    branch_case(3'd0, 32'd9, 32'd9, 1'b1);
    alu_case(4'd0, 2'd0, 1'b0, 32'd3, 32'd4, 0, 32'd7);
    branch_case(3'd1, 32'd9, 32'd9, 1'b0);
    branch_case(3'd4, 32'hFFFF_FFFF, 32'd1, 1'b1);
    branch_case(3'd7, 32'd1, 32'hFFFF_FFFF, 1'b0);
    branch_case(3'd3, 32'd1, 32'd1, 1'b0);
    branch_case(3'd6, 32'd1, 32'hFFFF_FFFF, 1'b1);

    // Compressed JALR and plain JAL.
    clear_inputs();
    in_valid = 1; in_jalr = 1; in_compressed = 1; in_pc = 32'h200; in_rs1_data = 32'h301;
    in_imm = 32'h4; in_rd = 5'd1; in_regwrite = 1;
    step(ev(1, 1, 0, 1, 32'h202, 5'd1));
    check("jalr_redirect_valid", redirect_valid, 1);
    check("jalr_redirect_pc", redirect_pc, 32'h304);
    squash2();
    clear_inputs();
    in_valid = 1; in_jal = 1; in_pc = 32'h40; in_imm = 32'h10; in_rd = 5'd1; in_regwrite = 1;
    step(ev(1, 1, 0, 1, 32'h44, 5'd1));
    check("jal_redirect_pc", redirect_pc, 32'h50);
    squash2();

    // Stall in the middle of a squash.
    drive_branch(3'd0, 32'd9, 32'd9);
    step(ev(1, 0, 0, 1, 32'd18, 5'd0));
    check("stall_redirect_valid", redirect_valid, 1);
    drive_wrong_path();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_redirect_drop", redirect_valid, 0);
      check("stall_hold_valid", out_valid, 1);
      check("stall_hold_result", out_alu_result, 32'd18);
    end
    stall = 0;
    squash2();
    alu_case(4'd0, 2'd0, 1'b0, 32'd20, 32'd22, 0, 32'd42);

    // Reset while in SQ1.
    drive_branch(3'd0, 32'd9, 32'd9);
    step(ev(1, 0, 0, 0, 0, 0));
    drive_wrong_path();
    step(ev(0, 0, 0, 0, 0, 0));
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    check("sq1_rst_valid", out_valid, 0);
    check("sq1_rst_result", out_alu_result, 0);
    check("sq1_rst_redirect", redirect_valid, 0);
    reset = 0;
    alu_case(4'd0, 2'd0, 1'b0, 32'd1, 32'd2, 0, 32'd3);

    clear_inputs();
    step(ev(0, 0, 0, 0, 0, 0));
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the RV32IC pipeline. It consumes the decoded fields latched by the ID/EX register, selects ALU operands with MEM/WB forwarding, computes the ALU result and resolves branches and jumps. Results are registered into the EX/MEM boundary. On a taken control transfer it issues a one-cycle fetch redirect and squashes the two wrong-path instructions that follow.

Parameters:
XLEN, 32, datapath width.
RESET_PC_DUMMY, 32'h0, value driven on redirect_pc while redirect_valid=0.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
stall  in  1  hold all EX/MEM outputs and internal state; the current input is not consumed
in_valid  in  1  ID/EX entry holds a real instruction
in_pc  in  32  instruction PC
in_rs1_data, in_rs2_data  in  32 each  register file read data
in_imm  in  32  sign-extended immediate
in_rs1, in_rs2, in_rd  in  5 each  register indices
in_alu_op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB; 11-15 give result 0
in_src_a  in  2  0 rs1, 1 pc, 2 zero, 3 zero
in_src_b  in  1  0 rs2, 1 imm
in_func3  in  3  branch condition / memory size
in_regwrite, in_memread, in_memwrite  in  1 each  control flags
in_branch, in_jal, in_jalr  in  1 each  control-transfer type
in_compressed  in  1  16-bit instruction; link is pc+2 instead of pc+4
fwd_mem_we, fwd_mem_rd, fwd_mem_data  in  1/5/32  EX/MEM writeback source
fwd_wb_we, fwd_wb_rd, fwd_wb_data  in  1/5/32  MEM/WB writeback source
out_valid  out  1  EX/MEM entry valid
out_alu_result  out  32  ALU result; link address for jal/jalr
out_store_data  out  32  forwarded rs2 value
out_rd  out  5  destination register
out_func3  out  3  func3
out_regwrite, out_memread, out_memwrite  out  1 each  control flags, gated by validity
redirect_valid  out  1  one-cycle fetch redirect
redirect_pc  out  32  redirect target
hazard  out  1  RAW hazard indication (FWD_EN off only)

Behaviour:
- Reset: all outputs 0 except redirect_pc=RESET_PC_DUMMY. Squash FSM goes to NORMAL. Reset mid-squash abandons the squash.
- Operand forwarding, per rs: MEM source if fwd_mem_we && fwd_mem_rd==rs && rs!=0; else WB source under the same condition; else register file data. MEM has priority over WB.
- ALU: shifts use operand B bits [4:0]. SRA is arithmetic. SLT is signed, SLTU unsigned. PASSB gives B. All arithmetic wraps mod 2^32.
- Branch compare on the forwarded rs1/rs2, selected by func3: 0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU. func3 2 or 3 means not taken.
- taken = eff_valid && (jal || jalr || (branch && cond)).
- Target: jalr gives (rs1+imm) with bit 0 cleared. Otherwise pc+imm.
- For jal/jalr, out_alu_result is the link address (pc+2 or pc+4).
- eff_valid = in_valid && state==NORMAL.
- Latency is 1 cycle. On each rising edge with !stall:
  - out_* capture the computed values.
  - out_valid=eff_valid.
  - out_regwrite, out_memread and out_memwrite are ANDed with eff_valid.
- stall=1: out_*, FSM and redirect_pc hold their values.
- Redirect timing: redirect_valid=1 for exactly one cycle after a non-stalled edge that captured a taken instruction, together with redirect_pc=target. It clears on the next edge regardless of stall.
- Squash FSM:
  - NORMAL to SQ2 on a non-stalled edge that captured a taken instruction.
  - SQ2 to SQ1, then SQ1 to NORMAL, each on a non-stalled edge. The input consumed at each of those edges is squashed (out_valid=0).
  - Squashed instructions never redirect. A taken instruction arriving while in SQ2/SQ1 is ignored.
  - stall freezes the FSM.

Optional Feature:
FWD_EN.
- Defined: forwarding as described above, and hazard is tied to 0.
- Undefined: forwarding muxes removed and operands are the raw in_rs*_data. hazard is combinational: 1 when in_valid && state==NORMAL and some rs!=0 matches fwd_mem_rd with fwd_mem_we, or fwd_wb_rd with fwd_wb_we. Upstream must stall on hazard; this block still treats stall as its only hold.

Test Plan:
- ADD: rs1=5, rs2=7, alu_op=0, src 0/0, rd=3, regwrite=1 -> next cycle out_valid=1, out_alu_result=12, out_rd=3, out_regwrite=1.
- Forwarding priority: in_rs1=4; fwd_mem {we=1, rd=4, data=0x10}; fwd_wb {we=1, rd=4, data=0x20}; in_rs1_data=1; imm=1, src_b=1 -> result 0x11. With fwd_mem_rd=0 and in_rs1=0 -> result 1.
- BEQ taken: pc=0x100, rs1=rs2=9, imm=0x20, func3=0 -> redirect_valid=1 for one cycle with redirect_pc=0x120. The next two consumed inputs give out_valid=0 and out_regwrite=0. The third input is valid.
- Compressed JALR: pc=0x200, rs1=0x301, imm=0x4, compressed=1 -> out_alu_result=0x202, redirect_pc=0x304.
- Stall mid-squash: taken branch, then stall=1 for 3 cycles -> outputs and FSM hold and redirect_valid drops after one cycle. After release, exactly 2 further inputs are squashed.
- Reset during SQ1: reset=1 -> all outputs 0. The next input after reset is captured valid.
